// File: rtl/core_pkg.sv
// Shared core definitions: word width, boot address and the fetch record
// carried from the instruction SRAM to the execute stage.
package core_pkg;
  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_t;
endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO of fetch records. A flush empties it in one edge
// and overrides a push in the same cycle.
module ifu_fifo
  import core_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_t        data,
  output fetch_t        head,
  output logic [CW-1:0] count
);

  fetch_t          mem [DEPTH];
  logic   [PW-1:0] wr_ptr;
  logic   [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; an empty FIFO presents zeros instead.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !flush) assert (count < CW'(DEPTH));
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch front end: owns the PC, drives the one-cycle-latency
// instruction SRAM and buffers responses for the execute stage.
module ifu_prefetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = core_pkg::RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] ins_a,
  output logic        ins_e,
  input  logic [31:0] ins,
  output logic        ifu_vld,
  output logic [31:0] ifu_pc,
  output logic [31:0] ifu_ins,
  input  logic        ifu_rdy,
  input  logic        branch,
  input  logic [31:0] branch_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc;
  logic [31:0]   fl_pc;
  logic          fl_vld;
  logic [31:0]   iss_pc;
  logic          deq;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  fetch_t        resp;
  fetch_t        head;
  logic          unused_bpc;

  assign deq    = ifu_vld & ifu_rdy & ~branch;
  assign iss_pc = branch ? {branch_pc[31:2], 2'b00} : pc;
  assign ins_a  = iss_pc[15:0];

  // Slots that will be occupied after this edge, counting the response
  // still on its way back from the SRAM.
  assign occ   = {1'b0, count} - (CW + 1)'(deq) + (CW + 1)'(fl_vld);
  assign ins_e = ~rst & (branch | (occ < (CW + 1)'(DEPTH)));

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      fl_vld <= 1'b0;
    end else begin
      fl_vld <= ins_e;
      if (ins_e) pc <= iss_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (ins_e) fl_pc <= iss_pc;
  end

  assign resp = '{pc: fl_pc, ins: ins};

  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fl_vld),
    .pop   (deq),
    .flush (branch),
    .data  (resp),
    .head  (head),
    .count (count)
  );

  assign ifu_vld    = (count != '0);
  assign ifu_pc     = head.pc;
  assign ifu_ins    = head.ins;
  assign unused_bpc = ^branch_pc[1:0];

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with an SRAM model returning
// A000_0000 + word index, and a queue of expected accepted PCs.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ins_a;
  logic        ins_e;
  logic [31:0] ins = 32'h0;
  logic        ifu_vld;
  logic [31:0] ifu_pc;
  logic [31:0] ifu_ins;
  logic        ifu_rdy = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_pc = 32'h0;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];

  ifu_prefetch dut (
    .clk       (clk),
    .rst       (rst),
    .ins_a     (ins_a),
    .ins_e     (ins_e),
    .ins       (ins),
    .ifu_vld   (ifu_vld),
    .ifu_pc    (ifu_pc),
    .ifu_ins   (ifu_ins),
    .ifu_rdy   (ifu_rdy),
    .branch    (branch),
    .branch_pc (branch_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ins_e) ins <= 32'hA000_0000 + 32'(ins_a[9:2]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic drv(input logic r, input logic rdy, input logic br, input logic [31:0] bpc);
    rst       = r;
    ifu_rdy   = rdy;
    branch    = br;
    branch_pc = bpc;
    #1;
  endtask

  // Score an accepted head against the queue, then move to the next cycle.
  task automatic adv();
    logic [31:0] e;
    if (!rst && ifu_rdy && !branch && ifu_vld) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("sb_pc", ifu_pc, e);
      chk("sb_ins", ifu_ins, 32'hA000_0000 + 32'(e[9:2]));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_vld", 32'(ifu_vld), 32'h0);
    chk("rst_pc", ifu_pc, 32'h0);
    chk("rst_ins", ifu_ins, 32'h0);
    chk("rst_ins_e", 32'(ins_e), 32'h0);
    chk("rst_ins_a", 32'(ins_a), 32'h0);
    adv();

    fill(32'h0);
    drv(1'b0, 1'b1, 1'b0, 32'h0);
    chk("c0_ins_e", 32'(ins_e), 32'h1);
    chk("c0_ins_a", 32'(ins_a), 32'h0);
    chk("c0_vld", 32'(ifu_vld), 32'h0);
    adv();
    chk("c1_vld", 32'(ifu_vld), 32'h0);
    chk("c1_ins_a", 32'(ins_a), 32'h4);
    adv();
    chk("c2_vld", 32'(ifu_vld), 32'h1);
    chk("c2_pc", ifu_pc, 32'h0);
    adv();

    for (int c = 3; c <= 8; c++) begin
      drv(1'b0, 1'b0, 1'b0, 32'h0);
      chk("stall_pc", ifu_pc, 32'h4);
      chk("stall_ins_e", 32'(ins_e), 32'h0);
      adv();
    end
    drv(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (8) adv();

    fill(32'h40);
    drv(1'b0, 1'b1, 1'b1, 32'h40);
    chk("br_ins_a", 32'(ins_a), 32'h40);
    chk("br_ins_e", 32'(ins_e), 32'h1);
    adv();
    drv(1'b0, 1'b1, 1'b0, 32'h0);
    chk("br_bubble_vld", 32'(ifu_vld), 32'h0);
    adv();
    chk("br_head_vld", 32'(ifu_vld), 32'h1);
    chk("br_head_pc", ifu_pc, 32'h40);
    repeat (3) adv();

    fill(32'h80);
    drv(1'b0, 1'b0, 1'b1, 32'h83);
    chk("mis_ins_a", 32'(ins_a), 32'h80);
    chk("mis_ins_e", 32'(ins_e), 32'h1);
    adv();
    drv(1'b0, 1'b0, 1'b0, 32'h0);
    adv();
    chk("mis_pc", ifu_pc, 32'h80);
    chk("mis_ins", ifu_ins, 32'hA000_0020);
    adv();
    drv(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (2) adv();

    fill(32'h100);
    drv(1'b0, 1'b1, 1'b1, 32'h100);
    chk("dbl1_ins_a", 32'(ins_a), 32'h100);
    adv();
    fill(32'h200);
    drv(1'b0, 1'b1, 1'b1, 32'h200);
    chk("dbl2_ins_a", 32'(ins_a), 32'h200);
    adv();
    drv(1'b0, 1'b1, 1'b0, 32'h0);
    chk("dbl_bubble_vld", 32'(ifu_vld), 32'h0);
    adv();
    chk("dbl_head_pc", ifu_pc, 32'h200);
    repeat (4) adv();

    // Head held plus a response arriving while reset is asserted.
    drv(1'b1, 1'b0, 1'b0, 32'h0);
    adv();
    fill(32'h0);
    drv(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rr_vld", 32'(ifu_vld), 32'h0);
    chk("rr_ins_e", 32'(ins_e), 32'h1);
    chk("rr_ins_a", 32'(ins_a), 32'h0);
    adv();
    chk("rr_c1_vld", 32'(ifu_vld), 32'h0);
    adv();
    chk("rr_c2_vld", 32'(ifu_vld), 32'h1);
    chk("rr_c2_pc", ifu_pc, 32'h0);
    repeat (4) adv();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Instruction-fetch front end of the core. It owns the PC, drives the instruction SRAM port (`ins_a`/`ins_e`/`ins`) and absorbs that SRAM's one-cycle read latency in a 2-entry prefetch buffer. It presents `{ifu_vld, ifu_pc, ifu_ins}` to the execute stage under a valid/ready handshake. A branch redirect flushes the buffer and kills any in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 2: prefetch buffer entries. Must be ≥2 for full throughput.
- `clk` in 1: the block's single clock; every register updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ins_a` out 16: byte address to instruction SRAM. The SRAM uses `ins_a[9:2]` as its word index.
- `ins_e` out 1: fetch enable. The SRAM registers `ins_a`/`ins_e` on `clk`, and `ins` is valid in the following cycle.
- `ins` in 32: instruction word returned by the SRAM.
- `ifu_vld` out 1: the buffer head is a valid instruction.
- `ifu_pc` out 32: PC of the buffer head.
- `ifu_ins` out 32: instruction at the buffer head.
- `ifu_rdy` in 1: execute accepts the head this cycle.
- `branch` in 1: redirect request, one-cycle pulse.
- `branch_pc` in 32: redirect target. Bits [1:0] are ignored and forced to 0.

## Operation
- **State:**
  - `pc`: next address to issue.
  - In-flight tag `{fl_vld, fl_pc}`: a fetch issued last cycle.
  - FIFO of `{pc, ins}` with `count`.
- **Issue condition:** `ins_e = !rst & (branch | (count - deq + fl_vld < DEPTH))`.
  - `deq = ifu_vld & ifu_rdy & !branch`.
- **Issue address:** `ins_a = branch ? branch_pc[15:0] & ~3 : pc[15:0]`.
  - On issue, `pc` becomes the issued address + 4 (32-bit add, wraps at 2^32).
  - `fl_vld`/`fl_pc` capture the issue.
- **Response:** when `fl_vld` is set, `{fl_pc, ins}` is pushed into the FIFO in that cycle. The issue rule guarantees the FIFO has space; a push into a full FIFO is an assertion failure.
- **Output:** `ifu_vld = count != 0`; `ifu_pc`/`ifu_ins` come from the head register with no combinational path from `ins`.
- **Dequeue:** pop the head when `deq`. Simultaneous push and pop in one cycle is legal and leaves `count` unchanged.
- **Redirect (`branch` = 1):**
  - FIFO cleared, `count` → 0.
  - Any response arriving next cycle for a pre-branch fetch is discarded: `fl_vld` is overwritten by the target fetch.
  - Target issued in the same cycle.
  - The head present during a `branch` cycle is not considered consumed.
- **`branch` while `ifu_rdy` = 0:** the redirect still happens.
- **Back-to-back branches:** the last one wins. Each cancels the previous target's in-flight fetch.

## Timing
- **Reset values:** `ifu_vld` = 0, `ifu_pc` = 0, `ifu_ins` = 0, `ins_e` = 0, `ins_a` = `RESET_PC[15:0]`, `pc` = `RESET_PC`, `count` = 0, `fl_vld` = 0.
- **Startup:** first cycle with `rst` = 0 is cycle 0.
  - Cycle 0: `ins_e` = 1, `ins_a` = `RESET_PC`.
  - Cycle 1: `ins` returns.
  - Cycle 2: `ifu_vld` = 1.
- **Latency:** issue → `ifu_vld` is 2 cycles; redirect → target at head is 2 cycles (2-cycle bubble).
- **Throughput:** with `ifu_rdy` held at 1, one instruction per cycle, consecutive PCs +4.
- **Stall:** with `ifu_rdy` = 0, issue stops once `count + fl_vld = DEPTH`.
  - Head and order are preserved; no instruction is lost or duplicated.
  - Resume on the first cycle `ifu_rdy` = 1.
- **Reset mid-operation:** `rst` clears everything on the next edge. A response arriving in the cycle after `rst` is ignored.

## Structure
- **Shared package `core_pkg`:**
  - `XLEN` = 32.
  - `RESET_PC`.
  - `typedef struct packed {logic [31:0] pc; logic [31:0] ins;} fetch_t`.
  - `NOP` = 32'h0000_0013, for debug only.
- **Sub-module `ifu_fifo`:** parameterised-depth sync FIFO of `fetch_t`.
  - Ports: `push`, `pop`, `flush`, `head`, `count`.
  - `flush` has priority over `push`.
- **Top level:** PC/issue logic, in-flight tag, redirect handling.

## Test plan
- **Reset/startup:** SRAM word `n` = 32'hA000_0000 + n, `ifu_rdy` = 1.
  - Expect `ifu_vld` at cycle 2 with pc 0 / ins A0000000.
  - Then pc 4, 8, 12 / ins A0000001, A0000002, A0000003 on consecutive cycles.
- **Stall:** `ifu_rdy` = 0 for cycles 3–8.
  - `ifu_pc` holds 4 during the stall.
  - `ins_e` = 0 once 2 entries are held.
  - After release, pc 4, 8, 12, … with no gap or duplicate.
- **Redirect:** `branch` = 1, `branch_pc` = 32'h40 at cycle 5.
  - `ins_a` = 16'h0040 in cycle 5.
  - Pre-branch entries are dropped.
  - `ifu_vld` with pc 0x40 at cycle 7, then 0x44.
- **Misaligned redirect / double branch:**
  - `branch_pc` = 32'h83 → fetch at 0x80.
  - Branches to 0x100 then 0x200 on consecutive cycles → only 0x200 onward appears.
- **Reset mid-stream:** assert `rst` for 1 cycle while `count` = 2 and a fetch is in flight.
  - `ifu_vld` = 0 the cycle after.
  - Restart from `RESET_PC` with 2-cycle latency; no stale instruction is delivered.
